// File: rtl/sid_wavegen_if.sv
// Control/data bundle between the voice accumulator stage and the SID waveform stage.
// master drives phase, pulse width and control; slave (sid_wavegen) returns the waveform.
interface sid_wavegen_if #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned OUT_W = 12
);
    logic [ACC_W-1:0] acc_in;
    logic [11:0]      pw;
    logic [3:0]       wave_sel;
    logic             test;
    logic             ring_mod;
    logic             ring_msb;
    logic [OUT_W-1:0] wave_out;

    modport master (
        output acc_in,
        output pw,
        output wave_sel,
        output test,
        output ring_mod,
        output ring_msb,
        input  wave_out
    );

    modport slave (
        input  acc_in,
        input  pw,
        input  wave_sel,
        input  test,
        input  ring_mod,
        input  ring_msb,
        output wave_out
    );
endinterface

// File: rtl/sid_wavegen.sv
// SID 6581 oscillator waveform stage: triangle/saw/pulse/noise selection, noise LFSR, ring mod.
// Optional macro SID_ZERO_HOLD_EN: wave_sel=0 holds the previous output instead of driving zero.
module sid_wavegen #(
    parameter int unsigned         ACC_W     = 24,
    parameter int unsigned         OUT_W     = 12,
    parameter int unsigned         LFSR_W    = 23,
    parameter logic [LFSR_W-1:0]   LFSR_SEED = 23'h7FFFF8
) (
    input  logic          clk,
    input  logic          rst,
    sid_wavegen_if.slave  bus
);

    localparam int unsigned NoiseClkBit = 19;

    logic [OUT_W-1:0]  wave_q;
    logic [OUT_W-1:0]  wave_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              b19_q;

    logic [OUT_W-1:0]  saw;
    logic [OUT_W-1:0]  tri_w;
    logic [OUT_W-1:0]  pul;
    logic [OUT_W-1:0]  nse;
    logic [OUT_W-1:0]  mix;
    logic              msb_x;
    logic              noise_clk;

    // Waveform generators, all purely combinational from the current phase and LFSR.
    always_comb begin
        saw   = bus.acc_in[ACC_W-1 -: OUT_W];
        // Ring modulation flips the triangle fold direction with the modulating voice's MSB.
        msb_x = bus.acc_in[ACC_W-1] ^ (bus.ring_mod & bus.ring_msb);
        tri_w = msb_x ? ~bus.acc_in[ACC_W-2 -: OUT_W] : bus.acc_in[ACC_W-2 -: OUT_W];
        pul   = (bus.test || (saw >= bus.pw)) ? '1 : '0;
        nse   = {lfsr_q[22], lfsr_q[20], lfsr_q[16], lfsr_q[13],
                 lfsr_q[11], lfsr_q[7],  lfsr_q[4],  lfsr_q[2], 4'b0000};
    end

    // Selected waveforms are wire-ANDed together, as on the real chip.
    always_comb begin
        mix = '1;
        if (bus.wave_sel[0]) mix = mix & tri_w;
        if (bus.wave_sel[1]) mix = mix & saw;
        if (bus.wave_sel[2]) mix = mix & pul;
        if (bus.wave_sel[3]) mix = mix & nse;
        wave_d = mix;
        if (bus.wave_sel == 4'b0000) begin
`ifdef SID_ZERO_HOLD_EN
            wave_d = wave_q;
`else
            wave_d = '0;
`endif
        end
    end

    // Noise register clocks on the rising edge of phase bit 19; test reseeds and wins.
    always_comb begin
        noise_clk = bus.acc_in[NoiseClkBit] & ~b19_q;
        lfsr_d    = lfsr_q;
        if (bus.test) begin
            lfsr_d = LFSR_SEED;
        end else if (noise_clk) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[22] ^ lfsr_q[17]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wave_q <= '0;
            lfsr_q <= LFSR_SEED;
            b19_q  <= 1'b0;
        end else begin
            wave_q <= wave_d;
            lfsr_q <= lfsr_d;
            b19_q  <= bus.acc_in[NoiseClkBit];
        end
    end

    assign bus.wave_out = wave_q;

endmodule

// File: tb/tb_sid_wavegen.sv
// Directed self-checking bench for sid_wavegen; expected values are hand-derived constants.
module tb_sid_wavegen;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sid_wavegen_if #(.ACC_W(24), .OUT_W(12)) bus ();

    sid_wavegen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        bus.acc_in   = '0;
        bus.pw       = '0;
        bus.wave_sel = 4'b0000;
        bus.test     = 1'b0;
        bus.ring_mod = 1'b0;
        bus.ring_msb = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_defaults();
        tick();
        rst = 1'b1;
    endtask

    task automatic noise_rises(input int n);
        for (int i = 0; i < n; i++) begin
            bus.acc_in = 24'h080000;
            tick();
            bus.acc_in = 24'h000000;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_defaults();
        bus.wave_sel = 4'b0010;
        bus.acc_in   = 24'h123456;
        #1;
        total++;
        if (bus.wave_out !== 12'h000) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", bus.wave_out, 12'h000);
        end
        tick();
        total++;
        if (bus.wave_out !== 12'h000) begin
            bad++;
            $display("FAIL reset_clocked: got %h want %h", bus.wave_out, 12'h000);
        end
        rst = 1'b1;
        bus.acc_in = 24'h000000;
        tick();
    endtask

    task automatic test_sawtooth();
        bus.wave_sel = 4'b0010;
        bus.acc_in   = 24'h123456;
        #1;
        total++;
        if (bus.wave_out !== 12'h000) begin
            bad++;
            $display("FAIL saw_latency: got %h want %h", bus.wave_out, 12'h000);
        end
        tick();
        total++;
        if (bus.wave_out !== 12'h123) begin
            bad++;
            $display("FAIL saw: got %h want %h", bus.wave_out, 12'h123);
        end
    endtask

    task automatic test_pulse();
        bus.wave_sel = 4'b0100;
        bus.pw       = 12'd2047;
        bus.acc_in   = 24'h7FF000;
        tick();
        total++;
        if (bus.wave_out !== 12'hFFF) begin
            bad++;
            $display("FAIL pulse_eq: got %h want %h", bus.wave_out, 12'hFFF);
        end
        bus.acc_in = 24'h7FE000;
        tick();
        total++;
        if (bus.wave_out !== 12'h000) begin
            bad++;
            $display("FAIL pulse_below: got %h want %h", bus.wave_out, 12'h000);
        end
        bus.test   = 1'b1;
        bus.acc_in = 24'h000000;
        tick();
        total++;
        if (bus.wave_out !== 12'hFFF) begin
            bad++;
            $display("FAIL pulse_test: got %h want %h", bus.wave_out, 12'hFFF);
        end
        bus.test = 1'b0;
    endtask

    task automatic test_triangle();
        bus.wave_sel = 4'b0001;
        bus.acc_in   = 24'h400000;
        tick();
        total++;
        if (bus.wave_out !== 12'h800) begin
            bad++;
            $display("FAIL tri_rise: got %h want %h", bus.wave_out, 12'h800);
        end
        bus.acc_in = 24'h800000;
        tick();
        total++;
        if (bus.wave_out !== 12'hFFF) begin
            bad++;
            $display("FAIL tri_fold: got %h want %h", bus.wave_out, 12'hFFF);
        end
        bus.ring_mod = 1'b1;
        bus.ring_msb = 1'b1;
        bus.acc_in   = 24'h400000;
        tick();
        total++;
        if (bus.wave_out !== 12'h7FF) begin
            bad++;
            $display("FAIL tri_ring: got %h want %h", bus.wave_out, 12'h7FF);
        end
        bus.ring_mod = 1'b0;
        tick();
        total++;
        if (bus.wave_out !== 12'h800) begin
            bad++;
            $display("FAIL tri_ring_off: got %h want %h", bus.wave_out, 12'h800);
        end
        bus.ring_msb = 1'b0;
    endtask

    task automatic test_noise();
        do_reset();
        bus.wave_sel = 4'b1000;
        tick();
        total++;
        if (bus.wave_out !== 12'hFE0) begin
            bad++;
            $display("FAIL noise_seed: got %h want %h", bus.wave_out, 12'hFE0);
        end
        // 3 shifts of the seed: lfsr 7FFFC0
        noise_rises(3);
        total++;
        if (bus.wave_out !== 12'hFC0) begin
            bad++;
            $display("FAIL noise_3: got %h want %h", bus.wave_out, 12'hFC0);
        end
        // 20 shifts total: lfsr 00001F, tap feedback starts inserting ones at shift 16
        noise_rises(17);
        total++;
        if (bus.wave_out !== 12'h030) begin
            bad++;
            $display("FAIL noise_20: got %h want %h", bus.wave_out, 12'h030);
        end
    endtask

    task automatic test_test_bit();
        bus.wave_sel = 4'b1000;
        bus.test     = 1'b1;
        bus.acc_in   = 24'h080000;
        tick();
        tick();
        total++;
        if (bus.wave_out !== 12'hFE0) begin
            bad++;
            $display("FAIL test_reseed: got %h want %h", bus.wave_out, 12'hFE0);
        end
        bus.test = 1'b0;
        tick();
        total++;
        if (bus.wave_out !== 12'hFE0) begin
            bad++;
            $display("FAIL test_release: got %h want %h", bus.wave_out, 12'hFE0);
        end
        bus.acc_in = 24'h000000;
        tick();
    endtask

    task automatic test_async_reset();
        bus.wave_sel = 4'b1000;
        noise_rises(3);
        total++;
        if (bus.wave_out !== 12'hFC0) begin
            bad++;
            $display("FAIL areset_pre: got %h want %h", bus.wave_out, 12'hFC0);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.wave_out !== 12'h000) begin
            bad++;
            $display("FAIL areset_mid: got %h want %h", bus.wave_out, 12'h000);
        end
        #1;
        rst = 1'b1;
        tick();
        total++;
        if (bus.wave_out !== 12'hFE0) begin
            bad++;
            $display("FAIL areset_reseed: got %h want %h", bus.wave_out, 12'hFE0);
        end
    endtask

    task automatic test_combined();
        logic [11:0] zero_exp;
        do_reset();
        bus.wave_sel = 4'b1111;
        bus.acc_in   = 24'h800000;
        tick();
        total++;
        if (bus.wave_out !== 12'h800) begin
            bad++;
            $display("FAIL all_four: got %h want %h", bus.wave_out, 12'h800);
        end
        bus.wave_sel = 4'b0110;
        bus.pw       = 12'h000;
        bus.acc_in   = 24'hABC000;
        tick();
        total++;
        if (bus.wave_out !== 12'hABC) begin
            bad++;
            $display("FAIL saw_and_pulse: got %h want %h", bus.wave_out, 12'hABC);
        end
`ifdef SID_ZERO_HOLD_EN
        zero_exp = 12'hABC;
`else
        zero_exp = 12'h000;
`endif
        bus.wave_sel = 4'b0000;
        tick();
        total++;
        if (bus.wave_out !== zero_exp) begin
            bad++;
            $display("FAIL zero_sel: got %h want %h", bus.wave_out, zero_exp);
        end
        bus.acc_in = 24'h123000;
        tick();
        total++;
        if (bus.wave_out !== zero_exp) begin
            bad++;
            $display("FAIL zero_sel_2: got %h want %h", bus.wave_out, zero_exp);
        end
    endtask

    task automatic test_boundaries();
        bus.wave_sel = 4'b0100;
        bus.pw       = 12'h000;
        bus.acc_in   = 24'h000000;
        tick();
        total++;
        if (bus.wave_out !== 12'hFFF) begin
            bad++;
            $display("FAIL pw_zero: got %h want %h", bus.wave_out, 12'hFFF);
        end
        bus.pw     = 12'hFFF;
        bus.acc_in = 24'hFFF000;
        tick();
        total++;
        if (bus.wave_out !== 12'hFFF) begin
            bad++;
            $display("FAIL pw_max_hi: got %h want %h", bus.wave_out, 12'hFFF);
        end
        bus.acc_in = 24'hFFE000;
        tick();
        total++;
        if (bus.wave_out !== 12'h000) begin
            bad++;
            $display("FAIL pw_max_lo: got %h want %h", bus.wave_out, 12'h000);
        end
        bus.wave_sel = 4'b0010;
        bus.acc_in   = 24'hFFFFFF;
        tick();
        total++;
        if (bus.wave_out !== 12'hFFF) begin
            bad++;
            $display("FAIL saw_top: got %h want %h", bus.wave_out, 12'hFFF);
        end
        bus.acc_in = 24'h000000;
        tick();
        total++;
        if (bus.wave_out !== 12'h000) begin
            bad++;
            $display("FAIL saw_wrap: got %h want %h", bus.wave_out, 12'h000);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        set_defaults();
        test_reset();
        test_sawtooth();
        test_pulse();
        test_triangle();
        test_noise();
        test_test_bit();
        test_async_reset();
        test_combined();
        test_boundaries();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sid_wavegen.md
Name: sid_wavegen

Overview:
- Oscillator waveform stage of the SID 6581 voice. Sits directly downstream of the per-voice phase accumulator.
- Consumes the 24-bit accumulator phase and the 12-bit pulse width, and produces the 12-bit selected waveform (triangle, sawtooth, pulse, noise) for the envelope/DAC stage.
- Contains the 23-bit noise LFSR and the ring-modulation path.

Parameters:
- ACC_W, 24, accumulator phase width.
- OUT_W, 12, waveform output width.
- LFSR_W, 23, noise shift register width.
- LFSR_SEED, 23'h7FFFF8, LFSR value after reset and while test is high.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- acc_in  in  ACC_W  phase from the accumulator.
- pw  in  12  pulse width.
- wave_sel  in  4  bit0 triangle, bit1 sawtooth, bit2 pulse, bit3 noise.
- test  in  1  SID test bit.
- ring_mod  in  1  ring modulation enable.
- ring_msb  in  1  acc MSB of the modulating (previous) voice.
- wave_out  out  OUT_W  registered waveform.

Behaviour:
- Interface: one clock (clk). rst is asynchronous and active-low: asserting it immediately forces all state. Release is synchronous to clk.
- Reset values:
  - wave_out = 0.
  - lfsr = LFSR_SEED.
  - b19_q = 0 (registered acc_in[19]).
- Latency: wave_out is registered. The value on wave_out after edge N is computed from the inputs and LFSR state present just before edge N (1 cycle).
- Sawtooth: saw = acc_in[23:12].
- Triangle:
  - msb_x = acc_in[23] ^ (ring_mod & ring_msb).
  - tri = msb_x ? ~acc_in[22:11] : acc_in[22:11].
- Pulse:
  - pul = (acc_in[23:12] >= pw) ? 12'hFFF : 12'h000 (unsigned compare).
  - test=1 forces pul = 12'hFFF.
- Noise:
  - nse = {lfsr[22], lfsr[20], lfsr[16], lfsr[13], lfsr[11], lfsr[7], lfsr[4], lfsr[2], 4'b0000}.
- LFSR clocking:
  - Every edge, b19_q <= acc_in[19].
  - When acc_in[19]=1 and b19_q=0 (rising phase bit 19): lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
  - At most one shift per clock.
- Test:
  - While test=1, lfsr <= LFSR_SEED every edge.
  - Test wins over a simultaneous bit-19 rise.
  - b19_q still tracks acc_in[19].
- Combination:
  - wave_out <= bitwise AND of all selected waveforms.
  - wave_sel=4'b0000 gives the zero-select behaviour (see Optional Feature).
- Ring modulation affects only the triangle waveform.
- The mid-operation reset rule applies even when wave_sel changes every cycle: rst low immediately zeroes wave_out and reseeds the LFSR, regardless of accumulator state.
- Accumulator wrap (FFFFFF->000000): no special handling. Saw drops to 0, triangle continues its fold, and bit 19 edge detection remains correct across the wrap.
- pw=0: pulse is constantly FFF. pw=FFF: pulse is high only when acc_in[23:12]=FFF.

Optional Feature:
- Macro: SID_ZERO_HOLD_EN.
- Defined: wave_sel=0 holds wave_out at its previous value, modelling the 6581 DAC floating output. Reset still clears it.
- Undefined: wave_sel=0 drives wave_out to 12'h000 on the next edge.

Test Plan:
- Sawtooth: wave_sel=0010, acc_in=24'h123456 -> wave_out=12'h123 one cycle later.
- Pulse at pw=2047, wave_sel=0100:
  - acc_in=24'h7FF000 -> 12'hFFF.
  - acc_in=24'h7FE000 -> 12'h000.
  - test=1 with acc_in=0 -> 12'hFFF.
- Triangle/ring, wave_sel=0001:
  - acc_in=24'h400000 -> 12'h800.
  - acc_in=24'h800000 -> 12'hFFF.
  - ring_mod=1, ring_msb=1, acc_in=24'h400000 -> 12'h7FF.
- Noise, wave_sel=1000:
  - After reset -> 12'hFE0.
  - Toggle acc_in between 24'h000000 and 24'h080000 to give exactly 3 rising bit-19 events -> lfsr=23'h7FFFC0, wave_out=12'hFC0.
- Test and reset:
  - Assert test during noise for 2 cycles with a bit-19 rise present -> lfsr=LFSR_SEED, wave_out=12'hFE0.
  - Pulse rst low asynchronously mid-cycle -> wave_out=0 before the next clk edge.
- Combined/zero select:
  - wave_sel=0110, pw=0, acc_in=24'hABC000 -> 12'hABC.
  - Then wave_sel=0000 -> 12'h000 (macro off), or holds 12'hABC (SID_ZERO_HOLD_EN on).
